// File: rtl/axis_demux_pkg.sv
// Shared types and constants for the AXI-Stream demultiplexer slice.
package axis_demux_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROUTE,
    DROP
  } demux_state_t;

  localparam int unsigned DROP_CNT_WIDTH  = 16;
  localparam int unsigned AXIS_ID_WIDTH   = 4;
  localparam int unsigned AXIS_USER_WIDTH = 1;

endpackage

// File: rtl/axis_if.sv
// AXI-Stream bundle; optional sideband fields appear only when their *_PRESENT define is set.
interface axis_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEST_WIDTH = 4
);
  import axis_demux_pkg::*;

  logic                  TVALID;
  logic                  TREADY;
  logic [DATA_WIDTH-1:0] TDATA;
  logic                  TLAST;
  logic [DEST_WIDTH-1:0] TDEST;
`ifdef TSTRB_PRESENT
  logic [DATA_WIDTH/8-1:0] TSTRB;
`endif
`ifdef TKEEP_PRESENT
  logic [DATA_WIDTH/8-1:0] TKEEP;
`endif
`ifdef TID_PRESENT
  logic [AXIS_ID_WIDTH-1:0] TID;
`endif
`ifdef TUSER_PRESENT
  logic [AXIS_USER_WIDTH-1:0] TUSER;
`endif

  modport m (
    output TVALID, TDATA, TLAST, TDEST
`ifdef TSTRB_PRESENT
    , TSTRB
`endif
`ifdef TKEEP_PRESENT
    , TKEEP
`endif
`ifdef TID_PRESENT
    , TID
`endif
`ifdef TUSER_PRESENT
    , TUSER
`endif
    , input TREADY
  );

  modport s (
    input TVALID, TDATA, TLAST, TDEST
`ifdef TSTRB_PRESENT
    , TSTRB
`endif
`ifdef TKEEP_PRESENT
    , TKEEP
`endif
`ifdef TID_PRESENT
    , TID
`endif
`ifdef TUSER_PRESENT
    , TUSER
`endif
    , output TREADY
  );

endinterface

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-Stream skid buffer; s.TREADY is a pure register output (not-full).
module axis_skid_buf
  import axis_demux_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEST_WIDTH = 4
) (
  input  logic aclk,
  input  logic aresetn,
  axis_if.s    s,
  axis_if.m    m
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;
    logic [DEST_WIDTH-1:0] tdest;
`ifdef TSTRB_PRESENT
    logic [DATA_WIDTH/8-1:0] tstrb;
`endif
`ifdef TKEEP_PRESENT
    logic [DATA_WIDTH/8-1:0] tkeep;
`endif
`ifdef TID_PRESENT
    logic [AXIS_ID_WIDTH-1:0] tid;
`endif
`ifdef TUSER_PRESENT
    logic [AXIS_USER_WIDTH-1:0] tuser;
`endif
  } beat_t;

  beat_t       mem [2];
  beat_t       wr_beat;
  beat_t       rd_beat;
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic [1:0]  count_d;
  logic        ready_q;
  logic        push;
  logic        pop;

  always_comb begin
    wr_beat       = '0;
    wr_beat.tdata = s.TDATA;
    wr_beat.tlast = s.TLAST;
    wr_beat.tdest = s.TDEST;
`ifdef TSTRB_PRESENT
    wr_beat.tstrb = s.TSTRB;
`endif
`ifdef TKEEP_PRESENT
    wr_beat.tkeep = s.TKEEP;
`endif
`ifdef TID_PRESENT
    wr_beat.tid   = s.TID;
`endif
`ifdef TUSER_PRESENT
    wr_beat.tuser = s.TUSER;
`endif
  end

  assign push    = s.TVALID & ready_q;
  assign pop     = m.TREADY & (count != 2'd0);
  assign count_d = count + {1'b0, push} - {1'b0, pop};

  // ready_q resets low and tracks "not full" of the next count, so it never depends on m.TREADY combinationally
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      count   <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      count   <= count_d;
      ready_q <= (count_d != 2'd2);
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= wr_beat;
  end

  assign rd_beat  = mem[rd_ptr];
  assign s.TREADY = ready_q;
  assign m.TVALID = (count != 2'd0);
  assign m.TDATA  = rd_beat.tdata;
  assign m.TLAST  = rd_beat.tlast;
  assign m.TDEST  = rd_beat.tdest;
`ifdef TSTRB_PRESENT
  assign m.TSTRB  = rd_beat.tstrb;
`endif
`ifdef TKEEP_PRESENT
  assign m.TKEEP  = rd_beat.tkeep;
`endif
`ifdef TID_PRESENT
  assign m.TID    = rd_beat.tid;
`endif
`ifdef TUSER_PRESENT
  assign m.TUSER  = rd_beat.tuser;
`endif

endmodule

// File: rtl/axis_if_demux.sv
// Packet-aware AXI-Stream demultiplexer: routes whole packets by TDEST, drops and counts out-of-range ones.
module axis_if_demux
  import axis_demux_pkg::*;
#(
  parameter int unsigned CHANNEL_NUMBER       = 5,
  parameter int unsigned CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER),
  parameter int unsigned DATA_WIDTH           = 32,
  parameter int unsigned DEST_WIDTH           = 4
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  axis_if.s                         in,
  input  logic                      en,
  axis_if.m                         out [CHANNEL_NUMBER],
  output logic                      busy,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);

  axis_if #(.DATA_WIDTH(DATA_WIDTH), .DEST_WIDTH(DEST_WIDTH)) hd ();

  axis_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEST_WIDTH(DEST_WIDTH)
  ) u_skid (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s       (in),
    .m       (hd)
  );

  demux_state_t                    state_q, state_d;
  logic [CHANNEL_NUMBER_WIDTH-1:0] dest_q, dest_d, sel_idx;
  logic                            sel_valid;
  logic                            pop;
  logic                            drop_inc;
  logic                            dest_ok;
  logic [CHANNEL_NUMBER-1:0]       out_ready;

  assign dest_ok = (32'(hd.TDEST) < CHANNEL_NUMBER);

  // IDLE decides straight from the buffer head so a new packet's first beat goes out with no bubble
  always_comb begin
    state_d   = state_q;
    dest_d    = dest_q;
    sel_idx   = dest_q;
    sel_valid = 1'b0;
    pop       = 1'b0;
    drop_inc  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hd.TVALID && en) begin
          if (dest_ok) begin
            sel_idx   = hd.TDEST[CHANNEL_NUMBER_WIDTH-1:0];
            sel_valid = 1'b1;
            pop       = out_ready[sel_idx];
            if (pop && !hd.TLAST) begin
              state_d = ROUTE;
              dest_d  = sel_idx;
            end
          end else begin
            pop      = 1'b1;
            drop_inc = 1'b1;
            if (!hd.TLAST) state_d = DROP;
          end
        end
      end
      ROUTE: begin
        sel_valid = hd.TVALID;
        pop       = hd.TVALID && out_ready[dest_q];
        if (pop && hd.TLAST) state_d = IDLE;
      end
      DROP: begin
        pop = hd.TVALID;
        if (pop && hd.TLAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign hd.TREADY = pop;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      dest_q   <= '0;
      drop_cnt <= '0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      if (drop_inc && (drop_cnt != '1)) drop_cnt <= drop_cnt + DROP_CNT_WIDTH'(1);
    end
  end

  assign busy = (state_q != IDLE);

  for (genvar i = 0; i < CHANNEL_NUMBER; i++) begin : g_out
    logic hit;
    assign hit           = sel_valid && (sel_idx == CHANNEL_NUMBER_WIDTH'(i));
    assign out[i].TVALID = hit;
    assign out[i].TDATA  = hit ? hd.TDATA : '0;
    assign out[i].TLAST  = hit ? hd.TLAST : 1'b0;
    assign out[i].TDEST  = hit ? hd.TDEST : '0;
`ifdef TSTRB_PRESENT
    assign out[i].TSTRB  = hit ? hd.TSTRB : '0;
`endif
`ifdef TKEEP_PRESENT
    assign out[i].TKEEP  = hit ? hd.TKEEP : '0;
`endif
`ifdef TID_PRESENT
    assign out[i].TID    = hit ? hd.TID : '0;
`endif
`ifdef TUSER_PRESENT
    assign out[i].TUSER  = hit ? hd.TUSER : '0;
`endif
    assign out_ready[i]  = out[i].TREADY;
  end

endmodule

// File: tb/tb_axis_if_demux.sv
// Self-checking bench for axis_if_demux: packet table plus hand-written corner sequences, scoreboarded outputs.
module tb_axis_if_demux;
  import axis_demux_pkg::*;

  localparam int NCH = 5;

  logic        aclk    = 1'b0;
  logic        aresetn = 1'b0;
  logic        en      = 1'b1;
  logic        busy;
  logic [15:0] drop_cnt;

  axis_if #(.DATA_WIDTH(32), .DEST_WIDTH(4)) in_if ();
  axis_if #(.DATA_WIDTH(32), .DEST_WIDTH(4)) out_if [NCH] ();

  axis_if_demux #(
    .CHANNEL_NUMBER (NCH),
    .DATA_WIDTH     (32),
    .DEST_WIDTH     (4)
  ) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .in       (in_if),
    .en       (en),
    .out      (out_if),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  always #5 aclk = ~aclk;

  logic        o_valid [NCH];
  logic        o_last  [NCH];
  logic        o_ready [NCH];
  logic [31:0] o_data  [NCH];
  logic [3:0]  o_dest  [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_tap
    assign o_valid[g]       = out_if[g].TVALID;
    assign o_last[g]        = out_if[g].TLAST;
    assign o_data[g]        = out_if[g].TDATA;
    assign o_dest[g]        = out_if[g].TDEST;
    assign out_if[g].TREADY = o_ready[g];
  end

  typedef struct {
    int          chan;
    logic [31:0] data;
    logic [3:0]  dest;
    logic        last;
  } exp_t;

  typedef struct {
    int          dest0;
    int          destn;
    int          nbeats;
    logic [31:0] base;
    int          exp_drops;
    int          exp_busy;
  } vec_t;

  exp_t sb [$];
  int   hs_log [$];
  int   checks       = 0;
  int   errors       = 0;
  int   cyc          = 0;
  int   busy_cycles  = 0;
  int   stall_cycles = 0;
  int   valid_cycles = 0;

  logic        prev_hold [NCH];
  logic [31:0] prev_data [NCH];

  task automatic fail(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    errors++;
    $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) fail(name, act, exp);
    else checks++;
  endtask

  // Output monitor: sampled on the falling edge, i.e. the values the next rising edge will see.
  always @(negedge aclk) begin
    int   nv;
    exp_t e;
    cyc++;
    nv = 0;
    if (!aresetn) begin
      for (int i = 0; i < NCH; i++) prev_hold[i] = 1'b0;
    end else begin
      if (busy) busy_cycles++;
      if (!in_if.TREADY) stall_cycles++;
      for (int i = 0; i < NCH; i++) begin
        if (prev_hold[i]) begin
          check("hold_valid", o_valid[i], 1);
          check("hold_data", o_data[i], prev_data[i]);
        end
        if (o_valid[i]) begin
          nv++;
          valid_cycles++;
          if (o_ready[i]) begin
            hs_log.push_back(cyc);
            if (sb.size() == 0) fail("unexpected_beat", o_data[i], 0);
            else begin
              e = sb.pop_front();
              check("beat_chan", i, e.chan);
              check("beat_data", o_data[i], e.data);
              check("beat_dest", o_dest[i], e.dest);
              check("beat_last", o_last[i], e.last);
            end
          end
        end else begin
          check("idle_zero", o_data[i] | {27'd0, o_last[i], o_dest[i]}, 0);
        end
        prev_hold[i] = o_valid[i] && !o_ready[i];
        prev_data[i] = o_data[i];
      end
      if (nv > 1) fail("onehot_valid", nv, 1);
    end
  end

  task automatic send_beat(input int dest, input logic [31:0] data, input logic last, input int chan);
    int   t;
    exp_t e;
    in_if.TVALID = 1'b1;
    in_if.TDATA  = data;
    in_if.TDEST  = dest[3:0];
    in_if.TLAST  = last;
    t = 0;
    @(negedge aclk);
    while (!in_if.TREADY && t < 200) begin
      @(negedge aclk);
      t++;
    end
    if (!in_if.TREADY) fail("in_ready_timeout", in_if.TREADY, 1);
    else if (chan >= 0) begin
      e.chan = chan;
      e.data = data;
      e.dest = dest[3:0];
      e.last = last;
      sb.push_back(e);
    end
    @(posedge aclk);
    #1;
    in_if.TVALID = 1'b0;
  endtask

  task automatic send_pkt(input int dest0, input int destn, input int n, input logic [31:0] base,
                          input int chan);
    for (int b = 0; b < n; b++)
      send_beat((b == 0) ? dest0 : destn, base + 32'(b), (b == n - 1), chan);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge aclk);
      t++;
    end
    check("drain_sb_empty", sb.size(), 0);
    repeat (3) @(posedge aclk);
    #1;
  endtask

  initial begin
    #200000;
    fail("watchdog", 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs [9];
    int   b0, s0, v0, h0, t, exp_v;

    in_if.TVALID = 1'b0;
    in_if.TDATA  = '0;
    in_if.TDEST  = '0;
    in_if.TLAST  = 1'b0;
    for (int i = 0; i < NCH; i++) o_ready[i] = 1'b1;

    vecs[0] = '{3, 3, 1, 32'h0000_0100, 0, 0};
    vecs[1] = '{1, 4, 4, 32'h0000_0200, 0, 1};
    vecs[2] = '{0, 0, 2, 32'h0000_0300, 0, 1};
    vecs[3] = '{7, 7, 3, 32'h0000_0400, 1, 1};
    vecs[4] = '{2, 2, 1, 32'h0000_0500, 1, 0};
    vecs[5] = '{4, 0, 3, 32'h0000_0600, 1, 1};
    vecs[6] = '{5, 5, 1, 32'h0000_0700, 2, 0};
    vecs[7] = '{15, 1, 2, 32'h0000_0800, 3, 1};
    vecs[8] = '{6, 6, 4, 32'h0000_0900, 4, 1};

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    for (int i = 0; i < NCH; i++) begin
      check("rst_out_valid", o_valid[i], 0);
      check("rst_out_fields", o_data[i] | {27'd0, o_last[i], o_dest[i]}, 0);
    end
    check("rst_in_ready", in_if.TREADY, 0);
    check("rst_busy", busy, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    check("in_ready_after_rst", in_if.TREADY, 1);

    // Packet table, each packet drained before the next
    for (int k = 0; k < 9; k++) begin
      b0    = busy_cycles;
      s0    = stall_cycles;
      v0    = valid_cycles;
      exp_v = (vecs[k].dest0 < NCH) ? vecs[k].nbeats : 0;
      send_pkt(vecs[k].dest0, vecs[k].destn, vecs[k].nbeats, vecs[k].base,
               (vecs[k].dest0 < NCH) ? vecs[k].dest0 : -1);
      drain();
      check($sformatf("vec%0d_drop_cnt", k), drop_cnt, vecs[k].exp_drops);
      check($sformatf("vec%0d_busy_seen", k), (busy_cycles != b0), vecs[k].exp_busy);
      check($sformatf("vec%0d_valid_cycles", k), valid_cycles - v0, exp_v);
      check($sformatf("vec%0d_no_stall", k), stall_cycles - s0, 0);
      check($sformatf("vec%0d_busy_end", k), busy, 0);
    end

    // Back-to-back packets to different channels: six beats in six consecutive cycles
    h0 = hs_log.size();
    send_pkt(1, 4, 4, 32'h0000_0A00, 1);
    send_pkt(0, 0, 2, 32'h0000_0B00, 0);
    drain();
    check("b2b_beats", hs_log.size() - h0, 6);
    if (hs_log.size() >= h0 + 6) check("b2b_span", hs_log[h0+5] - hs_log[h0], 5);

    // Random backpressure on out[2], forced low at first so the buffer fills
    s0 = stall_cycles;
    h0 = hs_log.size();
    fork
      send_pkt(2, 2, 16, 32'h0000_0C00, 2);
      begin
        o_ready[2] = 1'b0;
        repeat (4) @(posedge aclk);
        #1;
        repeat (60) begin
          @(posedge aclk);
          #1;
          o_ready[2] = 1'($urandom_range(0, 1));
        end
        o_ready[2] = 1'b1;
      end
    join
    drain();
    check("bp_stall_seen", (stall_cycles > s0), 1);
    check("bp_beats", hs_log.size() - h0, 16);

    // en low holds a pending beat; raising it starts the route, dropping it mid-route does not stop it
    en = 1'b0;
    v0 = valid_cycles;
    h0 = hs_log.size();
    fork
      send_pkt(4, 4, 5, 32'h0000_0D00, 4);
      begin
        repeat (6) @(negedge aclk);
        check("en0_no_valid", valid_cycles - v0, 0);
        check("en0_buf_full", in_if.TREADY, 0);
        @(posedge aclk);
        #1;
        en = 1'b1;
        t  = 0;
        @(negedge aclk);
        while (!busy && t < 50) begin
          @(negedge aclk);
          t++;
        end
        check("en1_route_busy", busy, 1);
        @(posedge aclk);
        #1;
        en = 1'b0;
      end
    join
    drain();
    check("en_route_beats", hs_log.size() - h0, 5);
    check("en_route_busy_end", busy, 0);
    en = 1'b1;

    // Reset in the middle of a packet
    send_beat(2, 32'h0000_0E00, 1'b0, 2);
    send_beat(2, 32'h0000_0E01, 1'b0, 2);
    in_if.TVALID = 1'b1;
    in_if.TDATA  = 32'h0000_0E02;
    in_if.TDEST  = 4'd2;
    in_if.TLAST  = 1'b0;
    #2;
    aresetn = 1'b0;
    #1;
    for (int i = 0; i < NCH; i++) begin
      check("mid_rst_out_valid", o_valid[i], 0);
      check("mid_rst_out_fields", o_data[i] | {27'd0, o_last[i], o_dest[i]}, 0);
    end
    check("mid_rst_drop_cnt", drop_cnt, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_if.TREADY, 0);
    sb.delete();
    in_if.TVALID = 1'b0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    h0 = hs_log.size();
    send_pkt(3, 3, 3, 32'h0000_0F00, 3);
    drain();
    check("post_rst_beats", hs_log.size() - h0, 3);
    check("post_rst_drop_cnt", drop_cnt, 0);
    check("post_rst_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
